// File: rtl/r512x32_pkg.sv
// Shared types and constants for the 512x32 RAM burst reader.
package r512x32_pkg;

  localparam int ADDR_W         = 9;
  localparam int DATA_W         = 32;
  localparam int LEN_W          = 10;
  localparam int RDR_FIFO_DEPTH = 4;
  localparam int RDR_CNT_W      = $clog2(RDR_FIFO_DEPTH + 1);
  localparam int STALL_W        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rdr_state_t;

endpackage

// File: rtl/r512x32_burst_reader_if.sv
// RAM read port plus output word stream of the burst reader.
interface r512x32_burst_reader_if;
  import r512x32_pkg::*;

  logic [ADDR_W-1:0] RA;
  logic              RClk_En;
  logic [DATA_W-1:0] RD;
  logic [DATA_W-1:0] DOut;
  logic              DValid;
  logic              DReady;
  logic              DLast;

  modport master (
    output RA, RClk_En, DOut, DValid, DLast,
    input  RD, DReady
  );

  modport slave (
    input  RA, RClk_En, DOut, DValid, DLast,
    output RD, DReady
  );

endinterface

// File: rtl/r512x32_rdr_fifo.sv
// Small synchronous FIFO holding returned read words until the stream accepts them.
module r512x32_rdr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/r512x32_burst_reader.sv
// Burst read engine: issues consecutive RAM reads and streams the data with backpressure.
// Optional stall counter enabled by defining R512X32_RDR_PERF_EN.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | issuing reads while FIFO occupancy + in-flight < 4
// DRAIN | all reads issued, waiting for the last beat to leave
// DONE  | one cycle, Done pulse
module r512x32_burst_reader
  import r512x32_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [LEN_W-1:0]  Len,
  r512x32_burst_reader_if.master bus,
  output logic              Busy,
  output logic              Done
`ifdef R512X32_RDR_PERF_EN
  ,
  output logic [STALL_W-1:0] StallCnt
`endif
);

  rdr_state_t           state_q;
  rdr_state_t           state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [LEN_W-1:0]     issue_rem_q;
  logic [LEN_W-1:0]     beat_rem_q;
  logic                 inflight_q;
  logic                 accept;
  logic                 issue;
  logic                 pop;
  logic                 fifo_empty;
  logic [RDR_CNT_W-1:0] fifo_count;
  logic [RDR_CNT_W-1:0] occ;
  logic [DATA_W-1:0]    fifo_head;

  // In-flight read already owns a FIFO slot, so it counts toward the limit.
  assign occ    = fifo_count + RDR_CNT_W'(inflight_q);
  assign accept = (state_q == IDLE) && Start;
  assign issue  = (state_q == RUN) && (occ < RDR_CNT_W'(RDR_FIFO_DEPTH));
  assign pop    = bus.DValid && bus.DReady;

  assign bus.RA      = addr_q;
  assign bus.RClk_En = issue;
  assign bus.DValid  = !fifo_empty;
  assign bus.DOut    = bus.DValid ? fifo_head : '0;
  assign bus.DLast   = bus.DValid && (beat_rem_q == LEN_W'(1));
  assign Busy        = (state_q != IDLE);
  assign Done        = (state_q == DONE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_rem_q <= '0;
      beat_rem_q  <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        addr_q      <= StartAddr;
        issue_rem_q <= Len;
        beat_rem_q  <= Len;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + 1'b1;
          issue_rem_q <= issue_rem_q - 1'b1;
        end
        if (pop) begin
          beat_rem_q <= beat_rem_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = (Len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue && (issue_rem_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (beat_rem_q == LEN_W'(1))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  r512x32_rdr_fifo #(
    .DEPTH (RDR_FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (RDR_CNT_W)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   (bus.RD),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef R512X32_RDR_PERF_EN
  always_ff @(posedge Clk) begin
    if (Rst || accept) begin
      StallCnt <= '0;
    end else if (bus.DValid && !bus.DReady && (StallCnt != '1)) begin
      StallCnt <= StallCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_r512x32_burst_reader.sv
// Directed self-checking bench for r512x32_burst_reader with a behavioural 512x32 RAM.
module tb_r512x32_burst_reader;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [8:0]  StartAddr;
  logic [9:0]  Len;
  logic        Busy;
  logic        Done;
`ifdef R512X32_RDR_PERF_EN
  logic [15:0] StallCnt;
`endif

  r512x32_burst_reader_if bus ();

  r512x32_burst_reader dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .StartAddr (StartAddr),
    .Len       (Len),
    .bus       (bus),
    .Busy      (Busy),
    .Done      (Done)
`ifdef R512X32_RDR_PERF_EN
    ,
    .StallCnt  (StallCnt)
`endif
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [512];
  logic        ram_en_s;
  logic [8:0]  ram_a_s;

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 32'(a) * 32'h01010101;
    bus.RD   = '0;
    ram_en_s = 1'b0;
    ram_a_s  = '0;
  end

  always @(negedge Clk) begin
    ram_en_s = bus.RClk_En;
    ram_a_s  = bus.RA;
  end

  always @(posedge Clk) begin
    if (ram_en_s) bus.RD <= mem[ram_a_s];
  end

  // Stream monitor and occupancy model, sampled mid-cycle.
  logic [31:0] beats [$];
  logic        lasts [$];
  logic [8:0]  issued [$];
  int occ_m, infl_m, max_tot, viol, stab_err;
  logic        prev_hold;
  logic [31:0] prev_dout;

  initial begin
    occ_m = 0; infl_m = 0; max_tot = 0; viol = 0; stab_err = 0;
    prev_hold = 1'b0; prev_dout = '0;
  end

  always @(negedge Clk) begin
    if (Rst) begin
      occ_m = 0; infl_m = 0; prev_hold = 1'b0;
    end else begin
      if (occ_m + infl_m > max_tot) max_tot = occ_m + infl_m;
      if (bus.RClk_En && (occ_m + infl_m >= 4)) viol++;
      if (bus.DValid !== (occ_m != 0)) viol++;
      if (prev_hold && (bus.DValid !== 1'b1 || bus.DOut !== prev_dout)) stab_err++;
      if (bus.RClk_En) issued.push_back(bus.RA);
      if (bus.DValid && bus.DReady) begin
        beats.push_back(bus.DOut);
        lasts.push_back(bus.DLast);
      end
      occ_m = occ_m + infl_m - ((bus.DValid && bus.DReady) ? 1 : 0);
      infl_m = bus.RClk_En ? 1 : 0;
      prev_hold = bus.DValid && !bus.DReady;
      prev_dout = bus.DOut;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    lasts.delete();
    issued.delete();
    max_tot = 0; viol = 0; stab_err = 0;
  endtask

  task automatic start(input logic [8:0] a, input logic [9:0] n);
    Start = 1'b1; StartAddr = a; Len = n;
    step();
    Start = 1'b0;
  endtask

  // mode 0: ready always; 1: one high, two low; 2: never ready.
  task automatic wait_done(input int mode, input int limit, output int cycles);
    int k;
    k = 0; cycles = 0;
    while (!Done && cycles < limit) begin
      bus.DReady = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'b0;
      step();
      cycles++; k++;
    end
    check("done_within_limit", {31'b0, Done}, 32'd1);
    bus.DReady = 1'b1;
  endtask

  task automatic check_burst(input string tag, input logic [8:0] a0, input int n);
    int nl;
    logic [8:0] a;
    nl = 0;
    check({tag, "_beat_count"}, 32'(beats.size()), 32'(n));
    check({tag, "_issue_count"}, 32'(issued.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = a0 + 9'(i);
      check($sformatf("%s_data%0d", tag, i), beats[i], 32'(a) * 32'h01010101);
      check($sformatf("%s_ra%0d", tag, i), 32'(issued[i]), 32'(a));
      if (lasts[i]) nl++;
    end
    check({tag, "_dlast_final"}, {31'b0, lasts[n-1]}, 32'd1);
    check({tag, "_dlast_once"}, 32'(nl), 32'd1);
    check({tag, "_occ_limit"}, 32'(viol), 32'd0);
    check({tag, "_hold_stable"}, 32'(stab_err), 32'd0);
  endtask

  int cyc;

  initial begin
    Rst = 1'b1; Start = 1'b0; StartAddr = '0; Len = '0; bus.DReady = 1'b1;
    step(); step();
    check("rst_ra", 32'(bus.RA), 32'd0);
    check("rst_rclk_en", {31'b0, bus.RClk_En}, 32'd0);
    check("rst_dout", bus.DOut, 32'd0);
    check("rst_dvalid", {31'b0, bus.DValid}, 32'd0);
    check("rst_dlast", {31'b0, bus.DLast}, 32'd0);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
`ifdef R512X32_RDR_PERF_EN
    check("rst_stallcnt", 32'(StallCnt), 32'd0);
`endif
    Rst = 1'b0;
    step();
    clear_mon();

    // Basic burst at 0x010, Len 4.
    start(9'h010, 10'd4);
    check("b1_first_issue_en", {31'b0, bus.RClk_En}, 32'd1);
    check("b1_first_issue_ra", 32'(bus.RA), 32'h010);
    check("b1_busy", {31'b0, Busy}, 32'd1);
    wait_done(0, 50, cyc);
    check("b1_done_latency", 32'(cyc), 32'd6);
    check_burst("b1", 9'h010, 4);
    check("b1_data0_literal", beats[0], 32'h10101010);
    check("b1_data3_literal", beats[3], 32'h13131313);
    step();
    check("b1_done_pulse", {31'b0, Done}, 32'd0);
    check("b1_idle_busy", {31'b0, Busy}, 32'd0);
    clear_mon();

    // Address wrap 0x1FE..0x001.
    start(9'h1FE, 10'd4);
    wait_done(0, 50, cyc);
    check_burst("wrap", 9'h1FE, 4);
    check("wrap_ra2_literal", 32'(issued[2]), 32'h000);
    check("wrap_data0_literal", beats[0], 32'hFFFFFFFE);
    step();
    clear_mon();

    // Len 16 with ready one-high/two-low.
    start(9'h020, 10'd16);
    wait_done(1, 300, cyc);
    check_burst("bp", 9'h020, 16);
    check("bp_fifo_filled", 32'(max_tot), 32'd4);
    step();
    clear_mon();

    // Len 0: immediate Done, nothing issued or streamed.
    start(9'h050, 10'd0);
    check("len0_done", {31'b0, Done}, 32'd1);
    check("len0_rclk_en", {31'b0, bus.RClk_En}, 32'd0);
    check("len0_dvalid", {31'b0, bus.DValid}, 32'd0);
    step();
    check("len0_done_clears", {31'b0, Done}, 32'd0);
    step(); step();
    check("len0_no_issue", 32'(issued.size()), 32'd0);
    check("len0_no_beats", 32'(beats.size()), 32'd0);
    clear_mon();

    // Start while busy is ignored.
    start(9'h080, 10'd3);
    step();
    Start = 1'b1; StartAddr = 9'h100; Len = 10'd5;
    step();
    Start = 1'b0;
    wait_done(0, 50, cyc);
    check_burst("busy_start", 9'h080, 3);
    step();
    check("busy_start_idle", {31'b0, Busy}, 32'd0);
    clear_mon();

    // Reset after 3 of 8 beats, then a fresh short burst.
    start(9'h0C0, 10'd8);
    cyc = 0;
    while (beats.size() < 3 && cyc < 50) begin
      step();
      cyc++;
    end
    check("mid_three_beats", 32'(beats.size()), 32'd3);
    Rst = 1'b1;
    step();
    check("mid_rst_ra", 32'(bus.RA), 32'd0);
    check("mid_rst_rclk_en", {31'b0, bus.RClk_En}, 32'd0);
    check("mid_rst_dout", bus.DOut, 32'd0);
    check("mid_rst_dvalid", {31'b0, bus.DValid}, 32'd0);
    check("mid_rst_dlast", {31'b0, bus.DLast}, 32'd0);
    check("mid_rst_busy", {31'b0, Busy}, 32'd0);
    check("mid_rst_done", {31'b0, Done}, 32'd0);
    Rst = 1'b0;
    step();
    clear_mon();
    start(9'h1F0, 10'd2);
    wait_done(0, 50, cyc);
    check("post_rst_latency", 32'(cyc), 32'd4);
    check_burst("post_rst", 9'h1F0, 2);
    step();
    clear_mon();

`ifdef R512X32_RDR_PERF_EN
    // Stall counter: ten cycles of valid without ready.
    bus.DReady = 1'b0;
    start(9'h000, 10'd4);
    cyc = 0;
    while (!bus.DValid && cyc < 20) begin
      step();
      cyc++;
    end
    check("perf_dvalid_seen", {31'b0, bus.DValid}, 32'd1);
    for (int i = 0; i < 10; i++) step();
    check("perf_stall_10", 32'(StallCnt), 32'd10);
    wait_done(0, 50, cyc);
    check("perf_stall_hold", 32'(StallCnt), 32'd10);
    check_burst("perf", 9'h000, 4);
    step();
    clear_mon();
    start(9'h010, 10'd2);
    check("perf_stall_clear", 32'(StallCnt), 32'd0);
    wait_done(0, 50, cyc);
    step();
    clear_mon();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
